load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly downstream of the single-cycle datapath, between its ALU address/store-data outputs and the data memory. It executes one RV32I load or store per request: byte-enable generation, load byte/half extraction, and sign/zero extension. It talks to a variable-latency synchronous memory over a req/ready handshake and stalls the datapath through oBusy until the access completes.

Parameters:
TIMEOUT, 64, memory wait cycles in REQ before the access is aborted with oError (used only when LSU_TIMEOUT_EN is defined).
TIMER_WIDTH, 8, width of the wait counter; must satisfy 2^TIMER_WIDTH > TIMEOUT.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
iStart  in  1  request strobe from datapath; sampled only in IDLE
iWrite  in  1  1 = store, 0 = load
iFunct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
iAddress  in  32  byte address (ALU result)
iStoreData  in  32  store data, right-aligned (rs2)
oBusy  out  1  high whenever state != IDLE
oDone  out  1  one-cycle completion pulse
oError  out  1  one-cycle pulse with oDone on misalignment, illegal funct3, or timeout
oLoadData  out  32  extended load result; held until the next load completes
oMemReq  out  1  memory request
oMemWe  out  1  memory write enable
oMemAddr  out  32  word address ({addr[31:2],2'b00})
oMemWData  out  32  lane-shifted store data
oMemBe  out  4  byte enables
iMemReady  in  1  memory accepted write / read data valid
iMemRData  in  32  memory read word

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0, including oLoadData; timer 0. Reset during REQ drops oMemReq in the same cycle.
- States: IDLE, REQ, RESP.
- IDLE:
  - iStart=1 latches iWrite, iFunct3, iAddress and iStoreData.
  - Misalignment is H/HU with addr[0]=1, or W with addr[1:0]!=0. Misaligned access or illegal funct3 -> RESP with error flagged; no memory access.
  - Otherwise -> REQ.
- REQ:
  - oMemReq=1; oMemWe, oMemAddr, oMemWData and oMemBe are held stable.
  - Each posedge with iMemReady=1 ends the transfer and moves to RESP. On a load, the extended data is latched into oLoadData at that edge.
  - Zero-wait is legal: iMemReady may be high in the first REQ cycle.
- RESP: oDone=1, plus oError if flagged; -> IDLE. oMemReq=0.
- Latency:
  - Zero-wait access: iStart edge T, REQ in cycle T+1, oDone in cycle T+2.
  - Each wait cycle adds one cycle.
  - Error path: oDone/oError in cycle T+1.
- iStart in any state other than IDLE is ignored. Back-to-back: a new iStart is accepted in the cycle after RESP.
- Byte enables (o = addr[1:0]):
  - B: 4'b0001<<o.
  - H: 4'b0011<<(2*o[1]).
  - W: 4'b1111.
  - Loads drive oMemBe the same way.
- Store data:
  - B: byte replicated to all four lanes.
  - H: halfword replicated to both halves.
  - W: passed unchanged.
- Load extraction:
  - B/BU: byte o of the read word.
  - H/HU: halfword o[1].
  - B/H sign-extend; BU/HU zero-extend.
- oLoadData is not updated on stores or errors.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - The timer clears on entry to REQ and increments every REQ cycle with iMemReady=0.
  - When the timer reaches TIMEOUT, oMemReq drops and the state moves to RESP with oError=1; oLoadData is unchanged.
  - iMemReady in that same cycle takes priority over the timeout.
- Undefined: no timer logic; REQ waits indefinitely; oError arises only from misalignment or illegal funct3.

Test Plan:
- Load, signed byte: LB at 0x103, memory returns 0x80FF_1234 with zero wait -> oLoadData=0xFFFF_FF80; oDone at T+2; oMemAddr=0x100; oMemBe=1000.
- Load, unsigned half: LHU at 0x202, word 0xBEEF_0001 -> oLoadData=0x0000_BEEF; oMemBe=1100.
- Store half with waits: SH 0x1234_ABCD at 0x006, iMemReady after 3 wait cycles -> oMemWData=0xABCD_ABCD, oMemBe=1100, oMemWe=1; req stays stable for 4 cycles; oDone at T+5; oBusy high for T+1..T+5.
- Misaligned word: SW at 0x00A -> oMemReq never rises; oDone=oError=1 at T+1; oLoadData unchanged.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT=4): LW with iMemReady held 0 -> oMemReq drops after 4 REQ cycles; oDone=oError=1 next cycle. Without the macro, oBusy stays high for 100 cycles.
- Reset mid-operation: assert reset_n=0 mid-REQ -> oMemReq/oBusy go 0 immediately. After release, a new LW at 0x0 with word 0x1 completes with oLoadData=0x1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: datapath request/response and data-memory handshake bundle.
// slave is the LSU view, master the datapath/memory view.
interface load_store_unit_if;
    logic        iStart;
    logic        iWrite;
    logic [2:0]  iFunct3;
    logic [31:0] iAddress;
    logic [31:0] iStoreData;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    logic [31:0] oLoadData;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemBe;
    logic        iMemReady;
    logic [31:0] iMemRData;
    modport slave (
        input  iStart, iWrite, iFunct3, iAddress, iStoreData, iMemReady, iMemRData,
        output oBusy, oDone, oError, oLoadData, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe
    );
    modport master (
        output iStart, iWrite, iFunct3, iAddress, iStoreData, iMemReady, iMemRData,
        input  oBusy, oDone, oError, oLoadData, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with lane steering and load extension.
// Define LSU_TIMEOUT_EN to abort memory waits longer than TIMEOUT cycles with an error.
module load_store_unit #(
    parameter int TIMEOUT     = 64,
    parameter int TIMER_WIDTH = 8
) (
    input logic               clock,
    input logic               reset_n,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t      r_state;
    logic        r_err;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_load;
    logic [1:0]  w_off;
    logic [2:0]  w_f3;
    logic        w_legal;
    logic        w_misal;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_timeout;

    if (TIMEOUT >= (64'd1 << TIMER_WIDTH)) begin : g_bad_timer
        $error("TIMER_WIDTH too narrow for TIMEOUT");
    end

    assign w_off   = bus.iAddress[1:0];
    assign w_f3    = bus.iFunct3;
    assign w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign w_misal = (w_f3[1:0] == 2'b01 && w_off[0]) || (w_f3[1:0] == 2'b10 && w_off != 2'b00);
    assign w_bad   = !w_legal || w_misal;
    assign w_be    = w_f3[1:0] == 2'b00 ? 4'b0001 << w_off :
                     w_f3[1:0] == 2'b01 ? 4'b0011 << {w_off[1], 1'b0} : 4'b1111;
    assign w_wdata = w_f3[1:0] == 2'b00 ? {4{bus.iStoreData[7:0]}} :
                     w_f3[1:0] == 2'b01 ? {2{bus.iStoreData[15:0]}} : bus.iStoreData;

    // Extraction uses the offset and width captured at request time.
    assign w_shift = bus.iMemRData >> {r_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_off[1] ? bus.iMemRData[31:16] : bus.iMemRData[15:0];
    assign w_ext   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_byte[7]}}, w_byte} :
                     r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half} : bus.iMemRData;

`ifdef LSU_TIMEOUT_EN
    logic [TIMER_WIDTH-1:0] r_timer;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_timer <= '0;
        else if (r_state != REQ)
            r_timer <= '0;
        else if (!bus.iMemReady)
            r_timer <= r_timer + 1'b1;
    end
    assign w_timeout = r_timer == TIMER_WIDTH'(TIMEOUT - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_load  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.iStart) begin
                    r_err   <= w_bad;
                    r_f3    <= w_f3;
                    r_off   <= w_off;
                    r_state <= w_bad ? RESP : REQ;
                    if (!w_bad) begin
                        r_we    <= bus.iWrite;
                        r_addr  <= {bus.iAddress[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                    end
                end
                REQ: if (bus.iMemReady) begin
                    r_state <= RESP;
                    if (!r_we)
                        r_load <= w_ext;
                end else if (w_timeout) begin
                    r_state <= RESP;
                    r_err   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oBusy     = r_state != IDLE;
    assign bus.oMemReq   = r_state == REQ;
    assign bus.oDone     = r_state == RESP;
    assign bus.oError    = r_state == RESP && r_err;
    assign bus.oLoadData = r_load;
    assign bus.oMemWe    = r_we;
    assign bus.oMemAddr  = r_addr;
    assign bus.oMemWData = r_wdata;
    assign bus.oMemBe    = r_be;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, random ops against a reference model, and reset/timeout sequences.
module tb_load_store_unit;
    localparam int TO = 4;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    load_store_unit_if bus ();
    load_store_unit #(.TIMEOUT(TO), .TIMER_WIDTH(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;

    typedef struct {
        logic w; logic [2:0] f3; logic [31:0] a, d, rd; int waits;
        logic err; logic [3:0] be; logic [31:0] wd, ld;
    } vec_t;
    vec_t tbl[11];

    int n_tests = 0, n_fail = 0;
    int cap_lat, cap_nreq;
    logic cap_err, cap_req, cap_unstable, cap_busy_bad, cap_we;
    logic [3:0] cap_be;
    logic [31:0] cap_wd, cap_addr;
    logic m_err;
    logic [3:0] m_be;
    logic [31:0] m_wd, m_load;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: derived from access width and offset with plain arithmetic.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, d, rd);
        int off, bytes, lane;
        longint val;
        off   = int'(a[1:0]);
        bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        m_err = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) || (off % bytes != 0);
        lane  = (off / bytes) * bytes;
        m_be  = 4'(((1 << bytes) - 1) << lane);
        m_wd  = bytes == 1 ? d[7:0] * 32'h0101_0101 : bytes == 2 ? d[15:0] * 32'h0001_0001 : d;
        val   = (longint'(rd) >> (8 * lane)) % (longint'(1) << (8 * bytes));
        if (f3 < 4 && bytes < 4 && val >= (longint'(1) << (8 * bytes - 1)))
            val = val - (longint'(1) << (8 * bytes));
        if (!w && !m_err)
            m_load = 32'(val);
    endtask

    // Issue one op at a negedge while idle; memory raises ready on the (waits+1)th REQ cycle.
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a, d, rd, input int waits);
        int idx = 0;
        bus.iStart = 1'b1; bus.iWrite = w; bus.iFunct3 = f3; bus.iAddress = a;
        bus.iStoreData = d; bus.iMemRData = rd; bus.iMemReady = 1'b0;
        @(negedge clock);
        bus.iStart = 1'b0;
        cap_lat = 1; cap_nreq = 0; cap_req = 0; cap_unstable = 0; cap_busy_bad = 0;
        while (!bus.oDone && cap_lat < 200) begin
            if (!bus.oBusy) cap_busy_bad = 1;
            if (bus.oMemReq) begin
                if (!cap_req) begin
                    cap_req = 1; cap_be = bus.oMemBe; cap_wd = bus.oMemWData;
                    cap_we = bus.oMemWe; cap_addr = bus.oMemAddr;
                end else if (cap_be !== bus.oMemBe || cap_wd !== bus.oMemWData ||
                             cap_we !== bus.oMemWe || cap_addr !== bus.oMemAddr)
                    cap_unstable = 1;
                cap_nreq++;
                bus.iMemReady = (idx == waits);
                idx++;
            end
            @(negedge clock);
            cap_lat++;
            bus.iMemReady = 1'b0;
        end
        cap_err = bus.oError;
        if (!bus.oBusy) cap_busy_bad = 1;
        @(negedge clock);
        if (bus.oBusy || bus.oDone) cap_busy_bad = 1;
    endtask

    task automatic check_op(input string nm, input logic w, input logic [31:0] a, input int waits,
                            input logic err, input logic [3:0] be, input logic [31:0] wd, ld);
        chk({nm, " latency"}, cap_lat, err ? 1 : waits + 2);
        chk({nm, " error"}, cap_err, err);
        chk({nm, " req_seen"}, cap_req, !err);
        chk({nm, " busy"}, cap_busy_bad, 0);
        chk({nm, " load_data"}, bus.oLoadData, ld);
        if (!err) begin
            chk({nm, " be"}, cap_be, be);
            chk({nm, " we"}, cap_we, w);
            chk({nm, " addr"}, cap_addr, {a[31:2], 2'b00});
            chk({nm, " req_stable"}, cap_unstable, 0);
            if (w) chk({nm, " wdata"}, cap_wd, wd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_codes[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        tbl[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 3'b101, 32'h202, 32'h0,         32'hBEEF_0001, 0, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF};
        tbl[2]  = '{1'b1, 3'b001, 32'h006, 32'h1234_ABCD, 32'h0,         3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_BEEF};
        tbl[3]  = '{1'b1, 3'b010, 32'h00A, 32'h1111_2222, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0000_BEEF};
        tbl[4]  = '{1'b0, 3'b010, 32'h010, 32'h0,         32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 3'b001, 32'h002, 32'h0,         32'h8001_0000, 2, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
        tbl[6]  = '{1'b0, 3'b100, 32'h001, 32'h0,         32'h0000_AB00, 0, 1'b0, 4'b0010, 32'h0,         32'h0000_00AB};
        tbl[7]  = '{1'b0, 3'b011, 32'h000, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0,         32'h0000_00AB};
        tbl[8]  = '{1'b0, 3'b001, 32'h005, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0,         32'h0000_00AB};
        tbl[9]  = '{1'b1, 3'b000, 32'h002, 32'hCAFE_0077, 32'h0,         1, 1'b0, 4'b0100, 32'h7777_7777, 32'h0000_00AB};
        tbl[10] = '{1'b1, 3'b010, 32'h020, 32'h1234_5678, 32'h0,         0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0000_00AB};
        bus.iStart = 0; bus.iWrite = 0; bus.iFunct3 = 0; bus.iAddress = 0;
        bus.iStoreData = 0; bus.iMemReady = 0; bus.iMemRData = 0;
        m_load = 32'h0;
        #3;
        chk("reset busy", bus.oBusy, 0);
        chk("reset done", bus.oDone, 0);
        chk("reset error", bus.oError, 0);
        chk("reset memreq", bus.oMemReq, 0);
        chk("reset loaddata", bus.oLoadData, 0);
        chk("reset be", bus.oMemBe, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].waits);
            check_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].waits,
                     tbl[i].err, tbl[i].be, tbl[i].wd, tbl[i].ld);
            model(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].rd);
        end

        for (int i = 0; i < 40; i++) begin
            logic w;
            logic [2:0] f3;
            logic [31:0] a, d, rd;
            int waits;
            w = 1'($urandom_range(0, 1));
            f3 = w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 7)];
            a = $urandom; d = $urandom; rd = $urandom;
            waits = $urandom_range(0, 3);
            model(w, f3, a, d, rd);
            run_op(w, f3, a, d, rd, waits);
            check_op($sformatf("rnd%0d", i), w, a, waits, m_err, m_be, m_wd, m_load);
        end

`ifdef LSU_TIMEOUT_EN
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h5A5A_5A5A, 1000);
        chk("timeout latency", cap_lat, TO + 1);
        chk("timeout req_cycles", cap_nreq, TO);
        chk("timeout error", cap_err, 1);
        chk("timeout load_unchanged", bus.oLoadData, m_load);
`else
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h5A5A_5A5A, 100);
        model(1'b0, 3'b010, 32'h40, 32'h0, 32'h5A5A_5A5A);
        check_op("nowait_limit", 1'b0, 32'h40, 100, 1'b0, 4'b1111, 32'h0, m_load);
        chk("nowait_limit req_cycles", cap_nreq, 101);
`endif

        bus.iStart = 1'b1; bus.iWrite = 1'b0; bus.iFunct3 = 3'b010; bus.iAddress = 32'h80;
        bus.iMemReady = 1'b0;
        @(negedge clock);
        bus.iStart = 1'b0;
        chk("midreq memreq_before", bus.oMemReq, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreq memreq_after", bus.oMemReq, 0);
        chk("midreq busy_after", bus.oBusy, 0);
        chk("midreq loaddata_cleared", bus.oLoadData, 0);
        m_load = 32'h0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(1'b0, 3'b010, 32'h0, 32'h0, 32'h1, 0);
        check_op("post_reset_lw", 1'b0, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
